// File: rtl/des_out_serializer_if.sv
// Bus between the DES core, the output serializer and the downstream byte sink.
// The slave modport is the serializer; the master modport is whoever drives blocks and accepts bytes.
interface des_out_serializer_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [0:63]   data_i;
    logic          valid_i;
    logic          ready_i;
    logic [0:7]    byte_o;
    logic          valid_o;
    logic          last_o;
    logic [LW-1:0] level_o;
    logic          overflow_o;
    logic [1:0]    state_o;

    // Handshake: a block is offered when valid_i=1 and is taken unless the buffer is full
    // (no back-pressure to the DES core; drops raise overflow_o). A byte moves downstream
    // on every clock edge where valid_o=1 and ready_i=1; outputs hold while ready_i=0.
    modport slave (
        input  data_i, valid_i, ready_i,
        output byte_o, valid_o, last_o, level_o, overflow_o, state_o
    );

    modport master (
        output data_i, valid_i, ready_i,
        input  byte_o, valid_o, last_o, level_o, overflow_o, state_o
    );
endinterface

// File: rtl/des_out_serializer.sv
// Buffers 64-bit DES result blocks in a small circular FIFO and emits them MSB-first,
// one byte per accepted transfer, with a sticky flag for blocks dropped while full.
module des_out_serializer #(
    parameter int DEPTH = 4
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    des_out_serializer_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_FULL   = 2'd2;

    logic [0:63]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [2:0]    k_q, k_d;
    logic          ovf_q, ovf_d;
    logic [1:0]    state_q, state_d;

    logic          full;
    logic          has_data;
    logic          wr_en;
    logic          xfer;
    logic          pop;
    logic [0:63]   head;

    always_comb begin
        // Fullness uses the registered level, so a same-cycle pop cannot make room for a write.
        full     = (level_q == FULL_LVL);
        has_data = (level_q != '0);
        wr_en    = bus.valid_i && !full;
        xfer     = has_data && bus.ready_i;
        pop      = xfer && (k_q == 3'd7);

        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + AW'(1) : rd_ptr_q;
        k_d      = xfer  ? k_q + 3'd1        : k_q;

        level_d = level_q;
        case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        ovf_d = ovf_q | (bus.valid_i & full);

        if (level_d == '0)
            state_d = ST_EMPTY;
        else if (level_d == FULL_LVL)
            state_d = ST_FULL;
        else
            state_d = ST_ACTIVE;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            k_q      <= '0;
            ovf_q    <= 1'b0;
            state_q  <= ST_EMPTY;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            k_q      <= k_d;
            ovf_q    <= ovf_d;
            state_q  <= state_d;
        end
    end

    // Storage is not reset; the level counter alone decides which entries are meaningful.
    always_ff @(posedge clk_i) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= bus.data_i;
    end

    assign head           = mem_q[rd_ptr_q];
    assign bus.byte_o     = has_data ? head[{k_q, 3'b000} +: 8] : 8'h00;
    assign bus.valid_o    = has_data;
    assign bus.last_o     = has_data && (k_q == 3'd7);
    assign bus.level_o    = level_q;
    assign bus.overflow_o = ovf_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_des_out_serializer.sv
// Bench for des_out_serializer: directed scenarios plus random traffic, checked against a
// block-queue model of the serializer's observable behaviour.
module tb_des_out_serializer;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk_i;
    logic reset_i;

    des_out_serializer_if #(.DEPTH(DEPTH)) bus ();

    des_out_serializer #(.DEPTH(DEPTH)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: blocks held, bytes already sent from the head, sticky drop flag.
    logic [63:0] m_q[$];
    int          m_k;
    logic        m_ovf;

    int n_asrt;
    int n_fail;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] head;
        logic [7:0]  exp_byte;
        logic [1:0]  exp_state;
        exp_byte = 8'h00;
        if (m_q.size() != 0) begin
            head     = m_q[0];
            exp_byte = 8'((head >> (56 - 8 * m_k)) & 64'hFF);
        end
        if (m_q.size() == 0)          exp_state = 2'd0;
        else if (m_q.size() == DEPTH) exp_state = 2'd2;
        else                          exp_state = 2'd1;
        chk({tag, ".valid"}, 64'(bus.valid_o),    64'(m_q.size() != 0));
        chk({tag, ".byte"},  64'(bus.byte_o),     64'(exp_byte));
        chk({tag, ".last"},  64'(bus.last_o),     64'((m_q.size() != 0) && (m_k == 7)));
        chk({tag, ".level"}, 64'(bus.level_o),    64'(m_q.size()));
        chk({tag, ".ovf"},   64'(bus.overflow_o), 64'(m_ovf));
        chk({tag, ".state"}, 64'(bus.state_o),    64'(exp_state));
    endtask

    task automatic model_edge(input logic v, input logic [63:0] d, input logic r);
        bit full;
        full = (m_q.size() == DEPTH);
        if (v && full) m_ovf = 1'b1;
        if (m_q.size() != 0 && r) begin
            if (m_k == 7) begin
                m_k = 0;
                void'(m_q.pop_front());
            end else begin
                m_k++;
            end
        end
        if (v && !full) m_q.push_back(d);
    endtask

    // Called at a falling edge: drive, take the rising edge, then check at the next falling edge.
    task automatic cycle(input string tag, input logic v, input logic [63:0] d, input logic r);
        bus.valid_i = v;
        bus.data_i  = d;
        bus.ready_i = r;
        @(posedge clk_i);
        model_edge(v, d, r);
        @(negedge clk_i);
        check_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        #2;
        reset_i = 1'b1;
        #1;
        m_q.delete();
        m_k   = 0;
        m_ovf = 1'b0;
        check_outputs({tag, ".in_reset"});
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        check_outputs({tag, ".released"});
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    initial begin
        n_asrt = 0;
        n_fail = 0;
        m_k    = 0;
        m_ovf  = 1'b0;
        reset_i     = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.data_i  = '0;

        // Power-on reset.
        @(negedge clk_i);
        check_outputs("por");
        @(negedge clk_i);
        reset_i = 1'b0;
        check_outputs("por_rel");

        // Single known block, ready held high.
        cycle("single.wr", 1'b1, 64'h85E813540F0AB405, 1'b1);
        chk("single.byte0", 64'(bus.byte_o), 64'h85);
        for (int i = 0; i < 9; i++) cycle("single.drain", 1'b0, '0, 1'b1);
        chk("single.empty", 64'(bus.level_o), 64'd0);

        // Back-pressure with ready toggling.
        cycle("bp.wr", 1'b1, rnd64(), 1'b0);
        for (int i = 0; i < 18; i++) cycle("bp.toggle", 1'b0, '0, (i % 2) == 0);

        // Overflow: five blocks into a depth-4 buffer with ready low.
        for (int i = 0; i < 5; i++) cycle("ovf.wr", 1'b1, rnd64(), 1'b0);
        chk("ovf.level", 64'(bus.level_o), 64'd4);
        chk("ovf.flag",  64'(bus.overflow_o), 64'd1);
        for (int i = 0; i < 34; i++) cycle("ovf.drain", 1'b0, '0, 1'b1);

        // Full buffer, head completing, and a write in the same cycle.
        do_reset("col.rst");
        for (int i = 0; i < 4; i++) cycle("col.fill", 1'b1, rnd64(), 1'b0);
        for (int i = 0; i < 7; i++) cycle("col.adv", 1'b0, '0, 1'b1);
        chk("col.last_pre", 64'(bus.last_o), 64'd1);
        cycle("col.hit", 1'b1, rnd64(), 1'b1);
        chk("col.level", 64'(bus.level_o), 64'd3);
        chk("col.ovf",   64'(bus.overflow_o), 64'd1);
        for (int i = 0; i < 26; i++) cycle("col.drain", 1'b0, '0, 1'b1);

        // Streaming at one block per 8 cycles.
        do_reset("stream.rst");
        for (int b = 0; b < 5; b++) begin
            cycle("stream.wr", 1'b1, rnd64(), 1'b1);
            for (int i = 0; i < 7; i++) begin
                cycle("stream.run", 1'b0, '0, 1'b1);
                chk("stream.lvl_le1", 64'(bus.level_o <= LW'(1)), 64'd1);
                chk("stream.cont",    64'(bus.valid_o), 64'd1);
            end
        end
        cycle("stream.tail", 1'b0, '0, 1'b1);
        chk("stream.ovf", 64'(bus.overflow_o), 64'd0);

        // Reset in the middle of a block with more queued behind it.
        do_reset("mid.rst0");
        for (int i = 0; i < 3; i++) cycle("mid.fill", 1'b1, rnd64(), 1'b0);
        for (int i = 0; i < 3; i++) cycle("mid.adv", 1'b0, '0, 1'b1);
        do_reset("mid.rst");
        cycle("mid.new", 1'b1, 64'h0123456789ABCDEF, 1'b1);
        chk("mid.byte0", 64'(bus.byte_o), 64'h01);
        for (int i = 0; i < 9; i++) cycle("mid.drain", 1'b0, '0, 1'b1);

        // Random traffic.
        do_reset("rnd.rst");
        for (int i = 0; i < 400; i++)
            cycle("rnd", $urandom_range(0, 3) == 0, rnd64(), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 40; i++) cycle("rnd.drain", 1'b0, '0, 1'b1);
        chk("rnd.empty", 64'(bus.level_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule
